sample_capture_sequencer: RTL

Sequences the per-channel sample shift buffers that sit behind the tile's 8-bit input port. Runs one capture cycle: on a programmable sample tick it steers one input sample into each enabled channel in round-robin order until every enabled channel holds a full buffer. It then drains all captured samples, channel by channel and oldest first, over a valid/ready stream. The block owns sequencing only; the buffer storage and data path sit in the parent.

---
 rtl/sample_capture_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sample_capture_sequencer.sv
// sample_capture_sequencer
// Sequences the per-channel sample shift buffers behind the tile's 8-bit input
// port. It captures DEPTH samples into every enabled channel in round-robin order
// on a programmable tick. It then drains them channel by channel, oldest first,
// over a valid/ready handshake. Buffer storage and the data path sit in the parent.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start with a nonzero channel mask
//   CAPTURE | tick counter running; one wr_en per tick, round-robin
//   DRAIN   | out_valid held high; rd_chan/rd_idx walk the captured data
module sample_capture_sequencer #(
  parameter int NUM_CHANNELS = 7,
  parameter int DEPTH        = 10,
  parameter int DIV_WIDTH    = 16,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DIV_WIDTH-1:0]    divider,
  input  logic [NUM_CHANNELS-1:0] chan_mask,
  output logic                    wr_en,
  output logic [CW-1:0]           wr_chan,
  output logic [CW-1:0]           rd_chan,
  output logic [IW-1:0]           rd_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t                  state;
  logic [DIV_WIDTH-1:0]    div_q;
  logic [DIV_WIDTH-1:0]    tick_cnt;
  logic [NUM_CHANNELS-1:0] mask_q;
  logic [IW-1:0]           round_cnt;

  logic [CW-1:0]           start_chan;
  logic [CW-1:0]           first_chan;
  logic [CW-1:0]           wr_next;
  logic [CW-1:0]           rd_next;
  logic                    wr_is_last_chan;
  logic                    rd_is_last_chan;
  logic [DIV_WIDTH-1:0]    tick_inc;

  function automatic logic [CW-1:0] lowest_chan(input logic [NUM_CHANNELS-1:0] m);
    logic [CW-1:0] r;
    r = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) r = CW'(i);
    end
    return r;
  endfunction

  // Next enabled channel above cur, wrapping to the lowest enabled one.
  function automatic logic [CW-1:0] next_chan(input logic [NUM_CHANNELS-1:0] m,
                                              input logic [CW-1:0] cur);
    logic [CW-1:0] r;
    r = lowest_chan(m);
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = CW'(i);
    end
    return r;
  endfunction

  function automatic logic is_highest(input logic [NUM_CHANNELS-1:0] m,
                                      input logic [CW-1:0] cur);
    logic h;
    h = 1'b1;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (m[i] && (i > int'(cur))) h = 1'b0;
    end
    return h;
  endfunction

  // Channel-walk helpers for the write and read pointers, and the tick increment.
  always_comb begin
    start_chan      = lowest_chan(chan_mask);
    first_chan      = lowest_chan(mask_q);
    wr_next         = next_chan(mask_q, wr_chan);
    rd_next         = next_chan(mask_q, rd_chan);
    wr_is_last_chan = is_highest(mask_q, wr_chan);
    rd_is_last_chan = is_highest(mask_q, rd_chan);
    tick_inc        = tick_cnt + DIV_WIDTH'(1);
  end

  assign busy = (state != IDLE);

  // Sequencer FSM. wr_en is registered one cycle ahead, so it is high exactly in
  // the cycle where tick_cnt equals the latched divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_q     <= '0;
      tick_cnt  <= '0;
      mask_q    <= '0;
      round_cnt <= '0;
      wr_en     <= 1'b0;
      wr_chan   <= '0;
      rd_chan   <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      wr_en     <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (|chan_mask)) begin
            div_q     <= divider;
            mask_q    <= chan_mask;
            tick_cnt  <= '0;
            round_cnt <= '0;
            wr_chan   <= start_chan;
            wr_en     <= (divider == '0);
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (wr_en) begin
            tick_cnt <= '0;
            wr_chan  <= wr_next;
            if (wr_is_last_chan && (round_cnt == IW'(DEPTH - 1))) begin
              wr_en     <= 1'b0;
              round_cnt <= '0;
              out_valid <= 1'b1;
              rd_chan   <= first_chan;
              rd_idx    <= '0;
              state     <= DRAIN;
            end else begin
              if (wr_is_last_chan) round_cnt <= round_cnt + IW'(1);
              wr_en <= (div_q == '0);
            end
          end else begin
            tick_cnt <= tick_inc;
            wr_en    <= (tick_inc == div_q);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == IW'(DEPTH - 1)) begin
              rd_idx <= '0;
              if (rd_is_last_chan) begin
                out_valid <= 1'b0;
                done      <= 1'b1;
                state     <= IDLE;
              end else begin
                rd_chan <= rd_next;
              end
            end else begin
              rd_idx <= rd_idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
